uart_transceiver: RTL and testbench

Full-duplex 8N1 UART that sits directly downstream of the SoC top-level MMIO decode. It serialises the byte in the transmit holding register onto `tx` when the core writes the UART data address. It deserialises `rx` into a byte with a valid pulse and a sticky ready flag, which the top latches into its receive holding register and line-status bit 0. Bit period is runtime-programmable through `baud_max`.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_if.sv | 21 ++
 rtl/uart_rx_unit.sv | 95 +++++++++
 rtl/uart_transceiver.sv | 110 +++++++++++
 tb/tb_uart_transceiver.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int BAUD_W = 16;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_if.sv
// MMIO-side handshake between the SoC decode (master) and the UART (slave).
interface uart_if import uart_pkg::*; ;
  logic [DATA_BITS-1:0] data;
  logic                 write_enable;
  logic                 busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 outValid;
  logic                 read_ready;
  logic                 negate_read_ready;
  logic [BAUD_W-1:0]    baud_max;

  modport master (
    output data, write_enable, negate_read_ready, baud_max,
    input  busy, rx_data, outValid, read_ready
  );

  modport slave (
    input  data, write_enable, negate_read_ready, baud_max,
    output busy, rx_data, outValid, read_ready
  );
endinterface

// File: rtl/uart_rx_unit.sv
// Receive path: rx synchroniser, falling-edge detect, mid-bit sampling FSM.
module uart_rx_unit import uart_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [BAUD_W-1:0]    baud_max,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 out_valid
);
  rx_state_t            state, state_n;
  logic [BAUD_W-1:0]    timer, timer_n;
  logic [BAUD_W-1:0]    baud_l, baud_l_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 out_valid_n;
  logic                 rx_s1, rx_s2, rx_s3;
  logic                 fall;

  // rx_s3 is the previous synchronised level, used only for edge detection
  assign fall = rx_s3 & ~rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1     <= LINE_IDLE;
      rx_s2     <= LINE_IDLE;
      rx_s3     <= LINE_IDLE;
      state     <= RX_IDLE;
      timer     <= '0;
      idx       <= '0;
      rx_data   <= '0;
      out_valid <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      rx_data   <= rx_data_n;
      out_valid <= out_valid_n;
    end
  end

  always_ff @(posedge clk) begin
    baud_l <= baud_l_n;
    shift  <= shift_n;
  end

  always_comb begin
    state_n     = state;
    timer_n     = timer + 16'd1;
    baud_l_n    = baud_l;
    shift_n     = shift;
    idx_n       = idx;
    rx_data_n   = rx_data;
    out_valid_n = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_n = '0;
        if (fall) begin
          state_n  = RX_START;
          baud_l_n = baud_max;
        end
      end
      RX_START: begin
        // A line that is high again at mid-start-bit was a glitch
        if (timer == (baud_l >> 1)) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer == baud_l) begin
          timer_n = '0;
          shift_n = {rx_s2, shift[DATA_BITS-1:1]};
          if (idx == 3'(DATA_BITS - 1)) state_n = RX_STOP;
          else                          idx_n   = idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (timer == baud_l) begin
          timer_n = '0;
          state_n = RX_IDLE;
          if (rx_s2) begin
            rx_data_n   = shift;
            out_valid_n = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: TX FSM and read_ready flag here, receive path in uart_rx_unit.
module uart_transceiver import uart_pkg::*; #(
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  uart_if.slave bus,
  input  logic rx,
  output logic tx
);
  tx_state_t            tx_state, tx_state_n;
  logic [BAUD_W-1:0]    tx_timer, tx_timer_n;
  logic [BAUD_W-1:0]    tx_baud, tx_baud_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic [2:0]           tx_idx, tx_idx_n;
  logic                 tx_q, tx_n;
  logic                 tx_bit_end;
  logic                 read_ready_q;

  assign tx_bit_end     = (tx_timer == tx_baud);
  assign tx             = tx_q;
  assign bus.busy       = (tx_state != TX_IDLE);
  assign bus.read_ready = read_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_idx   <= '0;
      tx_q     <= LINE_IDLE;
    end else begin
      tx_state <= tx_state_n;
      tx_timer <= tx_timer_n;
      tx_idx   <= tx_idx_n;
      tx_q     <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    tx_baud  <= tx_baud_n;
    tx_shift <= tx_shift_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_timer + 16'd1;
    tx_baud_n  = tx_baud;
    tx_shift_n = tx_shift;
    tx_idx_n   = tx_idx;
    tx_n       = tx_q;
    case (tx_state)
      TX_IDLE: begin
        tx_timer_n = '0;
        if (bus.write_enable) begin
          tx_state_n = TX_START;
          tx_baud_n  = bus.baud_max;
          tx_shift_n = bus.data;
          tx_idx_n   = '0;
          tx_n       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_n = TX_DATA;
          tx_timer_n = '0;
          tx_n       = tx_shift[0];
          tx_shift_n = tx_shift >> 1;
        end
      end
      TX_DATA: begin
        // tx_shift[0] always holds the bit that goes out next
        if (tx_bit_end) begin
          tx_timer_n = '0;
          if (tx_idx == 3'(DATA_BITS - 1)) begin
            tx_state_n = TX_STOP;
            tx_idx_n   = '0;
            tx_n       = LINE_IDLE;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_n       = tx_shift[0];
            tx_shift_n = tx_shift >> 1;
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_state_n = TX_IDLE;
          tx_timer_n = '0;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // A new byte beats a simultaneous read so it is never silently lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        read_ready_q <= 1'b0;
    else if (bus.outValid)          read_ready_q <= 1'b1;
    else if (bus.negate_read_ready) read_ready_q <= 1'b0;
  end

  uart_rx_unit u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .baud_max  (bus.baud_max),
    .rx_data   (bus.rx_data),
    .out_valid (bus.outValid)
  );
endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: TX framing, dropped writes, RX framing/glitch, read_ready, async reset.
module tb_uart_transceiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   ov_cnt    = 0;
  bit   ov_prev   = 1'b0;
  bit   ov_wide   = 1'b0;
  int   ov_base;
  bit   seen;
  logic [9:0] fr;

  uart_if u_if ();

  uart_transceiver dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if),
    .rx  (rx),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.outValid) ov_cnt = ov_cnt + 1;
    if (u_if.outValid && ov_prev) ov_wide = 1'b1;
    ov_prev = u_if.outValid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      rx = f[j];
      repeat (int'(u_if.baud_max) + 1) @(negedge clk);
    end
  endtask

  initial begin
    u_if.data              = 8'h00;
    u_if.write_enable      = 1'b0;
    u_if.negate_read_ready = 1'b0;
    u_if.baud_max          = 16'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_rx_data", u_if.rx_data, 0);
    chk("rst_outValid", u_if.outValid, 0);
    chk("rst_read_ready", u_if.read_ready, 0);

    // TX 8'hA5 at baud_max=3: line sequence 0,1,0,1,0,0,1,0,1,1 (bit j = fr[j])
    fr = 10'b1101001010;
    u_if.data = 8'hA5; u_if.write_enable = 1'b1;
    @(negedge clk);
    u_if.write_enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("tx_a5[%0d]", i), tx, fr[i/4]);
      chk($sformatf("busy_a5[%0d]", i), u_if.busy, 1);
      @(negedge clk);
    end
    chk("busy_a5_end", u_if.busy, 0);
    chk("tx_a5_idle", tx, 1);

    // TX 8'h96 with a write of 8'h3C five clocks in, which must be dropped
    fr = {1'b1, 8'h96, 1'b0};
    u_if.data = 8'h96; u_if.write_enable = 1'b1;
    @(negedge clk);
    u_if.write_enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("tx_96[%0d]", i), tx, fr[i/4]);
      if (i == 5) begin
        u_if.data = 8'h3C; u_if.write_enable = 1'b1;
      end else begin
        u_if.write_enable = 1'b0;
      end
      @(negedge clk);
    end
    u_if.write_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tx_after_96[%0d]", i), tx, 1);
      chk($sformatf("busy_after_96[%0d]", i), u_if.busy, 0);
      @(negedge clk);
    end

    // TX 8'h6B at baud_max=0: one clock per bit
    u_if.baud_max = 16'd0;
    fr = {1'b1, 8'h6B, 1'b0};
    u_if.data = 8'h6B; u_if.write_enable = 1'b1;
    @(negedge clk);
    u_if.write_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_b0[%0d]", i), tx, fr[i]);
      @(negedge clk);
    end
    chk("busy_b0_end", u_if.busy, 0);

    // RX 8'h5A at baud_max=7
    u_if.baud_max = 16'd7;
    repeat (4) @(negedge clk);
    ov_base = ov_cnt;
    send_rx(8'h5A, 1'b1, 10);
    repeat (4) @(negedge clk);
    chk("rx_5a_pulses", 16'(ov_cnt - ov_base), 1);
    chk("rx_5a_data", u_if.rx_data, 16'h5A);
    chk("rx_5a_ready", u_if.read_ready, 1);
    u_if.negate_read_ready = 1'b1;
    @(negedge clk);
    u_if.negate_read_ready = 1'b0;
    chk("rx_5a_negate", u_if.read_ready, 0);

    // Framing error: stop bit 0 discards the byte
    ov_base = ov_cnt;
    send_rx(8'h11, 1'b0, 10);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_pulses", 16'(ov_cnt - ov_base), 0);
    chk("ferr_data", u_if.rx_data, 16'h5A);
    chk("ferr_ready", u_if.read_ready, 0);

    // 2-clock glitch, then a good 8'hFF frame
    ov_base = ov_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_pulses", 16'(ov_cnt - ov_base), 0);
    chk("glitch_ready", u_if.read_ready, 0);
    send_rx(8'hFF, 1'b1, 10);
    repeat (4) @(negedge clk);
    chk("rx_ff_pulses", 16'(ov_cnt - ov_base), 1);
    chk("rx_ff_data", u_if.rx_data, 16'hFF);
    chk("rx_ff_ready", u_if.read_ready, 1);
    u_if.negate_read_ready = 1'b1;
    @(negedge clk);
    u_if.negate_read_ready = 1'b0;
    chk("rx_ff_negate", u_if.read_ready, 0);

    // outValid coinciding with negate_read_ready: set wins
    send_rx(8'hC3, 1'b1, 9);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(negedge clk);
      if (u_if.outValid) seen = 1'b1;
    end
    chk("coinc_seen", seen, 1);
    u_if.negate_read_ready = 1'b1;
    @(negedge clk);
    u_if.negate_read_ready = 1'b0;
    chk("coinc_ready", u_if.read_ready, 1);
    chk("coinc_pulse_width", u_if.outValid, 0);
    chk("coinc_data", u_if.rx_data, 16'hC3);
    @(negedge clk);
    chk("coinc_ready_hold", u_if.read_ready, 1);
    repeat (8) @(negedge clk);
    chk("ov_never_wide", ov_wide, 0);

    // Asynchronous reset in the middle of a TX frame
    u_if.baud_max = 16'd3;
    u_if.data = 8'h00; u_if.write_enable = 1'b1;
    @(negedge clk);
    u_if.write_enable = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    chk("pre_rst_busy", u_if.busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", u_if.busy, 0);
    chk("async_rst_rx_data", u_if.rx_data, 0);
    chk("async_rst_ready", u_if.read_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", u_if.busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
